// File: rtl/irq_input_conditioner.sv
// irq_input_conditioner: synchronize, glitch-filter and level/edge-condition raw interrupt lines
module irq_input_conditioner #(
  parameter int NUM_IRQ       = 26,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  input  logic [NUM_IRQ-1:0] edge_mode_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic [NUM_IRQ-1:0] clear_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] lost_o
);
  localparam int CW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]      r_cnt  [NUM_IRQ];
  logic [NUM_IRQ-1:0] r_filt, r_filt_q, r_pend, r_lost, r_irq;
  logic [NUM_IRQ-1:0] w_sync, w_rise, w_pend_nx, w_lost_nx, w_irq_nx;
  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign irq_o     = r_irq;
  assign pending_o = r_pend;
  assign lost_o    = r_lost;
  always_ff @(posedge aclk or posedge areset)
    if (areset)
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    else begin
      r_sync[0] <= irq_raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_filt <= '0;
      for (int n = 0; n < NUM_IRQ; n++) r_cnt[n] <= '0;
    end else
      for (int n = 0; n < NUM_IRQ; n++)
        if (FILTER_CYCLES == 0)
          r_filt[n] <= w_sync[n];
        else if (w_sync[n] == r_filt[n])
          r_cnt[n] <= '0;
        else if (int'(r_cnt[n]) + 1 >= FILTER_CYCLES) begin
          r_filt[n] <= w_sync[n];
          r_cnt[n]  <= '0;
        end else
          r_cnt[n] <= r_cnt[n] + CW'(1);
  always_comb begin
    w_rise    = r_filt & ~r_filt_q;
    w_pend_nx = edge_mode_i & (w_rise | (r_pend & ~clear_i));
    w_lost_nx = edge_mode_i & ~clear_i & (r_lost | (w_rise & r_pend));
    w_irq_nx  = ~mask_i & ((edge_mode_i & w_pend_nx) | (~edge_mode_i & r_filt));
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_filt_q <= '0;
      r_pend   <= '0;
      r_lost   <= '0;
      r_irq    <= '0;
    end else begin
      r_filt_q <= r_filt;
      r_pend   <= w_pend_nx;
      r_lost   <= w_lost_nx;
      r_irq    <= w_irq_nx;
    end
endmodule

// File: tb/tb_irq_input_conditioner.sv
// tb_irq_input_conditioner: directed vectors checked against a window-based behavioural model
module tb_irq_input_conditioner;
  localparam int N  = 26;
  localparam int SS = 2;
  localparam int FC = 3;
  localparam logic [N-1:0] ALL = '1;
  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic [N-1:0] irq_raw_i = '0, edge_mode_i = '0, mask_i = '0, clear_i = '0;
  logic [N-1:0] irq_o, pending_o, lost_o;
  int vectors = 0, miscompares = 0;
  irq_input_conditioner #(.NUM_IRQ(N), .SYNC_STAGES(SS), .FILTER_CYCLES(FC)) dut (
    .aclk(aclk), .areset(areset), .irq_raw_i(irq_raw_i), .edge_mode_i(edge_mode_i),
    .mask_i(mask_i), .clear_i(clear_i), .irq_o(irq_o), .pending_o(pending_o), .lost_o(lost_o)
  );
  always #5 aclk = ~aclk;
  logic [N-1:0] rh [SS+FC];
  logic [N-1:0] m_filt = '0, m_filtq = '0, m_pend = '0, m_lost = '0, m_irq = '0;
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < SS + FC; j++) rh[j] = '0;
      m_filt = '0; m_filtq = '0; m_pend = '0; m_lost = '0; m_irq = '0;
    end else begin
      logic [N-1:0] nf;
      logic rise, diff;
      for (int n = 0; n < N; n++) begin
        diff = 1'b1;
        for (int j = 0; j < FC; j++) if (rh[SS-1+j][n] == m_filt[n]) diff = 1'b0;
        if (FC == 0) diff = rh[SS-1][n] != m_filt[n];
        nf[n] = diff ? ~m_filt[n] : m_filt[n];
        rise = m_filt[n] & ~m_filtq[n];
        if (!edge_mode_i[n]) begin
          m_pend[n] = 1'b0;
          m_lost[n] = 1'b0;
          m_irq[n]  = m_filt[n] & ~mask_i[n];
        end else begin
          if (clear_i[n]) begin
            m_pend[n] = rise;
            m_lost[n] = 1'b0;
          end else begin
            if (rise && m_pend[n]) m_lost[n] = 1'b1;
            if (rise) m_pend[n] = 1'b1;
          end
          m_irq[n] = m_pend[n] & ~mask_i[n];
        end
      end
      m_filtq = m_filt;
      m_filt  = nf;
      for (int j = SS + FC - 1; j > 0; j--) rh[j] = rh[j-1];
      rh[0] = irq_raw_i;
    end
  end
  always @(negedge aclk) begin
    vectors += 3;
    if (irq_o !== m_irq) begin
      miscompares++;
      $display("FAIL model irq_o t=%0t: got %h want %h", $time, irq_o, m_irq);
    end
    if (pending_o !== m_pend) begin
      miscompares++;
      $display("FAIL model pending_o t=%0t: got %h want %h", $time, pending_o, m_pend);
    end
    if (lost_o !== m_lost) begin
      miscompares++;
      $display("FAIL model lost_o t=%0t: got %h want %h", $time, lost_o, m_lost);
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge aclk);
  endtask
  task automatic chkb(input string nm, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask
  task automatic chkv(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  initial begin
    #1 areset = 1'b1;
    step(3);
    chkv("reset irq", irq_o, '0);
    chkv("reset pending", pending_o, '0);
    chkv("reset lost", lost_o, '0);
    areset = 1'b0;
    edge_mode_i[8] = 1'b1;
    edge_mode_i[12] = 1'b1;
    step(4);
    irq_raw_i[0] = 1'b1;
    step(5);  chkb("level rise edge5", irq_o[0], 1'b0);
    step(1);  chkb("level rise edge6", irq_o[0], 1'b1);
    step(4);  irq_raw_i[0] = 1'b0;
    step(5);  chkb("level fall edge15", irq_o[0], 1'b1);
    step(1);  chkb("level fall edge16", irq_o[0], 1'b0);
    chkb("level pending", pending_o[0], 1'b0);
    chkb("level lost", lost_o[0], 1'b0);
    step(4);
    irq_raw_i[5] = 1'b1;
    step(2);  irq_raw_i[5] = 1'b0;
    step(4);  chkb("glitch2 edge6", irq_o[5], 1'b0);
    step(6);  chkb("glitch2 late", irq_o[5], 1'b0);
    irq_raw_i[5] = 1'b1;
    step(3);  irq_raw_i[5] = 1'b0;
    step(2);  chkb("pulse3 edge5", irq_o[5], 1'b0);
    step(1);  chkb("pulse3 edge6", irq_o[5], 1'b1);
    step(2);  chkb("pulse3 edge8", irq_o[5], 1'b1);
    step(1);  chkb("pulse3 edge9", irq_o[5], 1'b0);
    step(6);
    irq_raw_i[8] = 1'b1;
    step(5);  irq_raw_i[8] = 1'b0;
    chkb("edge pend edge5", pending_o[8], 1'b0);
    step(1);  chkb("edge pend edge6", pending_o[8], 1'b1);
    chkb("edge irq edge6", irq_o[8], 1'b1);
    step(14); chkb("edge pend held", pending_o[8], 1'b1);
    clear_i[8] = 1'b1;
    step(1);  clear_i[8] = 1'b0;
    chkb("clear pend", pending_o[8], 1'b0);
    chkb("clear irq", irq_o[8], 1'b0);
    step(5);
    irq_raw_i[8] = 1'b1;
    step(5);  irq_raw_i[8] = 1'b0;
    step(1);  chkb("pulseA pend", pending_o[8], 1'b1);
    step(9);
    irq_raw_i[8] = 1'b1;
    step(5);  irq_raw_i[8] = 1'b0; clear_i[8] = 1'b1;
    step(1);  clear_i[8] = 1'b0;
    chkb("set-wins pend", pending_o[8], 1'b1);
    chkb("set-wins lost", lost_o[8], 1'b0);
    step(9);
    irq_raw_i[8] = 1'b1;
    step(5);  irq_raw_i[8] = 1'b0;
    chkb("lost before", lost_o[8], 1'b0);
    step(1);  chkb("lost set", lost_o[8], 1'b1);
    chkb("lost pend", pending_o[8], 1'b1);
    step(3);  clear_i[8] = 1'b1;
    step(1);  clear_i[8] = 1'b0;
    chkb("lost clr pend", pending_o[8], 1'b0);
    chkb("lost clr lost", lost_o[8], 1'b0);
    chkb("lost clr irq", irq_o[8], 1'b0);
    step(6);
    irq_raw_i[12] = 1'b1;
    step(5);  irq_raw_i[12] = 1'b0;
    step(1);  chkb("mask pre irq", irq_o[12], 1'b1);
    mask_i[12] = 1'b1;
    step(1);  chkb("mask irq", irq_o[12], 1'b0);
    chkb("mask pend", pending_o[12], 1'b1);
    step(1);  mask_i[12] = 1'b0;
    step(1);  chkb("unmask irq", irq_o[12], 1'b1);
    step(5);  edge_mode_i[12] = 1'b0;
    step(1);  chkb("mode change pend", pending_o[12], 1'b0);
    chkb("mode change irq", irq_o[12], 1'b0);
    step(6);
    edge_mode_i = ALL;
    irq_raw_i = ALL;
    step(6);
    chkv("all irq", irq_o, ALL);
    chkv("all pend", pending_o, ALL);
    chkv("all lost", lost_o, '0);
    @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    chkv("async rst irq", irq_o, '0);
    chkv("async rst pend", pending_o, '0);
    chkv("async rst lost", lost_o, '0);
    step(2);
    areset = 1'b0;
    step(5);  chkv("rerun irq edge5", irq_o, '0);
    step(1);  chkv("rerun irq edge6", irq_o, ALL);
    chkv("rerun pend edge6", pending_o, ALL);
    irq_raw_i = '0;
    clear_i = ALL;
    step(1);  clear_i = '0;
    chkv("final clear pend", pending_o, '0);
    step(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/irq_input_conditioner.md
Name: irq_input_conditioner

Overview:
- Sits directly upstream of the peripherals wrapper (PLIC + timer) and drives its uart/spi/eth/irq_i interrupt inputs.
- Takes raw, possibly asynchronous interrupt lines from FPGA-side peripherals and synchronizes them into aclk.
- Glitch-filters each line, then presents it as a level or as a latched edge-pending bit, with per-line masking and lost-edge reporting.

Parameters:
- NUM_IRQ, 26, number of lines. Bit 0 = uart, 1 = spi, 2 = eth, 3..25 = irq_i[7..29].
- SYNC_STAGES, 2, synchronizer flops per line. Legal range 2..4.
- FILTER_CYCLES, 3, consecutive stable cycles required before the filtered state changes. 0 = filter bypassed.

Ports:
- aclk  input  1  system clock
- areset  input  1  asynchronous, active-high reset
- irq_raw_i  input  NUM_IRQ  raw interrupt lines, asynchronous to aclk
- edge_mode_i  input  NUM_IRQ  per line: 1 = rising-edge latched, 0 = level; quasi-static
- mask_i  input  NUM_IRQ  per line: 1 = suppress irq_o; does not affect pending
- clear_i  input  NUM_IRQ  write-1-to-clear pulse for pending and lost bits
- irq_o  output  NUM_IRQ  conditioned interrupts to the PLIC wrapper, registered
- pending_o  output  NUM_IRQ  edge-mode pending bits, unmasked
- lost_o  output  NUM_IRQ  sticky: an edge arrived while that line's pending bit was already set

Behaviour:
- Reset:
  - areset asserted clears immediately (asynchronously) all synchronizer flops, filter counters, filtered state, previous-filtered state, pending, lost and irq_o.
  - Asserting areset mid-operation drops every output to 0 in the same cycle, with no clock edge required.
- Synchronizer:
  - Chain of SYNC_STAGES flops per line; sync_out = last stage.
  - No logic between stages.
- Filter, per line:
  - Counter width is $clog2(FILTER_CYCLES+1), minimum 1.
  - If sync_out == filt: counter resets to 0.
  - Otherwise the counter increments. When it would reach FILTER_CYCLES, filt <= sync_out and the counter resets to 0.
  - A pulse shorter than FILTER_CYCLES stable cycles never reaches filt.
  - FILTER_CYCLES = 0: filt <= sync_out every cycle.
- Edge detection:
  - filt_q is a register of filt.
  - rise = filt & ~filt_q, one cycle wide.
- Level mode (edge_mode_i = 0):
  - irq_o <= filt & ~mask.
  - pending forced to 0.
  - lost held at 0.
- Edge mode (edge_mode_i = 1):
  - pending sets on rise, clears on clear_i.
  - rise and clear_i in the same cycle: set wins, pending stays 1.
  - irq_o <= pending_next & ~mask.
- Lost detection:
  - lost sets when rise occurs while pending = 1 and clear_i = 0.
  - lost clears on clear_i unless it is being set in the same cycle.
  - rise coincident with clear_i sets neither lost nor re-clears pending: pending stays 1.
- Mode change: switching a line from edge to level clears its pending and lost on the next edge.
- Mask: asserting mask drops irq_o on the next edge and does not alter pending. Deasserting mask with pending = 1 raises irq_o on the next edge.
- Latency from a stable change on irq_raw_i to irq_o is L = SYNC_STAGES + FILTER_CYCLES + 1 edges, in both modes and both directions (level mode).
- clear_i to irq_o deassert takes 1 edge.
- Lines are fully independent; no cross-line arbitration.

Test Plan:
- Parameters: SYNC_STAGES = 2, FILTER_CYCLES = 3, so L = 6.
- Level pass: edge_mode = 0, irq_raw_i[0] = 1 at cycle 0, held 10 cycles -> irq_o[0] = 1 from edge 6. Raw falls at cycle 10 -> irq_o[0] = 0 at edge 16. pending_o[0] and lost_o[0] stay 0.
- Glitch reject: irq_raw_i[5] high for 2 cycles -> irq_o[5], pending_o[5] and all filter-visible state remain 0. A 3-cycle pulse -> irq_o[5] high for exactly 3 cycles, starting at edge 6.
- Edge latch: edge_mode[8] = 1, 5-cycle raw pulse -> pending_o[8] and irq_o[8] rise at edge 6 and stay 1 after raw falls. clear_i[8] pulsed at cycle 20 -> both 0 at edge 21.
- Simultaneous set/clear and lost:
  - clear_i[8] coincident with rise -> pending stays 1, lost_o[8] stays 0.
  - Second 5-cycle pulse arriving while pending = 1 -> lost_o[8] = 1.
  - clear_i[8] -> pending_o[8] = 0 and lost_o[8] = 0 on the next edge.
- Mask: edge line 12 pending, mask_i[12] = 1 -> irq_o[12] = 0 on the next edge, pending_o[12] = 1. Mask released -> irq_o[12] = 1 on the next edge.
- Reset mid-operation: with irq_o = 0x3FFFFFF and all pending set, assert areset between clock edges -> irq_o, pending_o and lost_o = 0 immediately. After release with raw lines still high -> irq_o returns at edge 6; edge lines re-latch a fresh rise.
